id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 126 ++++++++++++
 tb/tb_id_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: RV32 integer decode stage with a 32-entry register file.
//   Decodes R-type (0110011) and I-type ALU (0010011) instructions into ALU
//   operands/op, destination and write-enable. All other encodings raise
//   illegal. Single output register slice with valid/ready handshake.
//   Optional macro ID_STAGE_BYPASS_EN: a same-cycle writeback to a nonzero
//   source register is forwarded to the operand read.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready/instr      instruction input handshake
//   wb_en/wb_rd/wb_data          register file write port
//   out_valid/out_ready          decode result handshake
//   alu_a, alu_b, alu_op         ALU operands and op
//   rd, rd_we, illegal           destination, write-enable, illegal flag
module id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);

  logic [XLEN-1:0] regs [32];

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  logic xfer;
  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  // Register file; x0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  logic [XLEN-1:0] rs1_val, rs2_val;
  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];
`ifdef ID_STAGE_BYPASS_EN
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs1) rs1_val = wb_data;
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs2) rs2_val = wb_data;
`endif
  end

  // Combinational decode of the incoming instruction.
  logic            is_r, is_i, is_shift, legal;
  logic [2:0]      dec_op;
  logic [XLEN-1:0] dec_b;
  always_comb begin
    is_r     = (opcode == 7'b0110011);
    is_i     = (opcode == 7'b0010011);
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    legal    = (is_r || is_i) && (funct3 != 3'b010) && (funct3 != 3'b011);
    // R-type: only funct7=0, or 0100000 for sub (sra is not supported).
    if (is_r && !(funct7 == 7'd0 || (funct7 == 7'b0100000 && funct3 == 3'b000)))
      legal = 1'b0;
    // I-type shifts: funct7 must be zero, rejecting srai.
    if (is_i && is_shift && funct7 != 7'd0)
      legal = 1'b0;

    dec_op = 3'b000;
    case (funct3)
      3'b000:  dec_op = (is_r && instr[30]) ? 3'b001 : 3'b000;
      3'b111:  dec_op = 3'b010;
      3'b110:  dec_op = 3'b011;
      3'b100:  dec_op = 3'b100;
      3'b001:  dec_op = 3'b110;
      3'b101:  dec_op = 3'b111;
      default: dec_op = 3'b000;
    endcase
    if (!legal) dec_op = 3'b000;

    if (is_r)          dec_b = rs2_val;
    else if (is_shift) dec_b = {{(XLEN-5){1'b0}}, instr[24:20]};
    else               dec_b = {{(XLEN-12){instr[31]}}, instr[31:20]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 3'b000;
      rd        <= 5'd0;
      rd_we     <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        alu_a     <= rs1_val;
        alu_b     <= dec_b;
        alu_op    <= dec_op;
        rd        <= instr[11:7];
        rd_we     <= legal && (instr[11:7] != 5'd0);
        illegal   <= !legal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed spec scenarios followed by randomized traffic checked
// against a behavioural model (register array + rule-based decode).
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, wb_en, out_valid, out_ready, rd_we, illegal;
  logic [31:0] instr, wb_data, alu_a, alu_b;
  logic [4:0]  wb_rd, rd;
  logic [2:0]  alu_op;

  int checks = 0;
  int failures = 0;

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .rd(rd), .rd_we(rd_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

`ifdef ID_STAGE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [31:0] mreg [32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] v);
    wb_en = 1'b1; wb_rd = r; wb_data = v;
    tick();
    wb_en = 1'b0;
    if (r != 0) mreg[r] = v;
  endtask

  task automatic issue(input logic [31:0] ins);
    in_valid = 1'b1; instr = ins; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] s2,
      input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] d, input logic [6:0] opc);
    return {f7, s2, s1, f3, d, opc};
  endfunction

  // Model read: pre-write value unless the forwarding option is built in.
  function automatic logic [31:0] rdreg(input logic [4:0] idx, input logic we,
      input logic [4:0] wr, input logic [31:0] wd);
    if (idx == 0) return 32'd0;
    if (BYP && we && wr == idx) return wd;
    return mreg[idx];
  endfunction

  // Reference decode from the ISA rules.
  function automatic void model(input logic [31:0] ins, input logic [31:0] v1, input logic [31:0] v2,
      output logic [31:0] ea, output logic [31:0] eb, output logic [2:0] eop,
      output logic [4:0] erd, output logic ewe, output logic eill);
    logic [2:0] optab [8];
    int f3, f7;
    bit rt, it, sh, ok;
    optab = '{3'd0, 3'd6, 3'd0, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2};
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    rt = ins[6:0] == 7'h33;
    it = ins[6:0] == 7'h13;
    sh = (f3 == 1 || f3 == 5);
    ok = (rt || it) && f3 != 2 && f3 != 3;
    if (rt && f7 != 0 && !(f7 == 32 && f3 == 0)) ok = 0;
    if (it && sh && f7 != 0) ok = 0;
    ea  = v1;
    eb  = rt ? v2 : (sh ? 32'(ins[24:20]) : 32'($signed(ins[31:20])));
    eop = ok ? ((rt && f3 == 0 && f7 == 32) ? 3'd1 : optab[f3]) : 3'd0;
    erd = ins[11:7];
    ewe = ok && erd != 0;
    eill = !ok;
  endfunction

  initial begin
    logic [31:0] ea, eb, ta, tb2;
    logic [2:0]  eop, top;
    logic [4:0]  erd, trd;
    logic        ev, ewe, eill, twe, till, ir, xf;
    logic [6:0]  opc, f7;
    logic [4:0]  s1, s2, d;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'd0;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rd", rd, 0);
    chk("rst_rd_we", rd_we, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Basic decode cases.
    wb(5'd1, 32'd5); wb(5'd2, 32'd10);
    issue(32'h002081B3);
    chk("add_valid", out_valid, 1); chk("add_a", alu_a, 5); chk("add_b", alu_b, 10);
    chk("add_op", alu_op, 0); chk("add_rd", rd, 3); chk("add_we", rd_we, 1); chk("add_ill", illegal, 0);
    issue(32'h402081B3);
    chk("sub_op", alu_op, 1);
    issue(32'h00209213);
    chk("slli_a", alu_a, 5); chk("slli_b", alu_b, 2); chk("slli_op", alu_op, 6); chk("slli_rd", rd, 4);
    issue(32'hFFF00293);
    chk("addi_a", alu_a, 0); chk("addi_b", alu_b, 32'hFFFFFFFF); chk("addi_op", alu_op, 0);
    chk("addi_rd", rd, 5); chk("addi_we", rd_we, 1);
    issue(32'h0020A1B3);
    chk("slt_ill", illegal, 1); chk("slt_we", rd_we, 0); chk("slt_op", alu_op, 0);
    issue(32'h4020D1B3);
    chk("sra_ill", illegal, 1);

    // Stall: outputs held, later writeback does not disturb them.
    issue(32'h002081B3);
    out_ready = 1'b0; in_valid = 1'b1; instr = enc(7'h20, 5'd2, 5'd1, 3'd0, 5'd6, 7'h33);
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd99;
    for (int k = 0; k < 3; k++) begin
      #2 chk("stall_in_ready", in_ready, 0);
      tick();
      wb_en = 1'b0;
      chk("stall_valid", out_valid, 1); chk("stall_a", alu_a, 5);
      chk("stall_op", alu_op, 0); chk("stall_rd", rd, 3);
    end
    mreg[1] = 32'd99;
    out_ready = 1'b1;
    #2 chk("unstall_in_ready", in_ready, 1);
    tick();
    chk("burst0_op", alu_op, 1); chk("burst0_a", alu_a, 99); chk("burst0_rd", rd, 6);
    instr = enc(7'h00, 5'd2, 5'd1, 3'd4, 5'd7, 7'h33);
    tick();
    chk("burst1_op", alu_op, 4); chk("burst1_rd", rd, 7); chk("burst1_valid", out_valid, 1);
    in_valid = 1'b0;

    // Same-cycle writeback vs read.
    wb(5'd1, 32'd5);
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd7;
    issue(32'h002081B3);
    wb_en = 1'b0; mreg[1] = 32'd7;
    chk("bypass_a", alu_a, BYP ? 32'd7 : 32'd5);
    tick();
    issue(32'h002081B3);
    chk("after_wb_a", alu_a, 7);

    // Reset in the middle of a stall.
    out_ready = 1'b0;
    tick();
    chk("prereset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("midrst_valid", out_valid, 0); chk("midrst_a", alu_a, 0);
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    @(negedge clk); rst_n = 1'b1;
    in_valid = 1'b1; instr = 32'h002081B3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("postrst_valid", out_valid, 1); chk("postrst_a", alu_a, 0);
    tick();
    chk("drain_valid", out_valid, 0);

    // Randomized traffic vs model.
    ev = 1'b0; ea = 0; eb = 0; eop = 0; erd = 0; ewe = 0; eill = 0;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: opc = 7'h33;
        4, 5, 6, 7: opc = 7'h13;
        default:    opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: f7 = 7'h00;
        6, 7:             f7 = 7'h20;
        default:          f7 = 7'($urandom);
      endcase
      s1 = 5'($urandom); s2 = 5'($urandom); d = 5'($urandom);
      instr = enc(f7, s2, s1, 3'($urandom), d, opc);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      wb_en = $urandom_range(0, 1);
      wb_rd = ($urandom_range(0, 3) == 0) ? s1 : 5'($urandom);
      wb_data = $urandom;
      #2;
      ir = !ev || out_ready;
      chk("rnd_in_ready", in_ready, ir);
      xf = in_valid && ir;
      if (xf) begin
        model(instr, rdreg(s1, wb_en, wb_rd, wb_data), rdreg(s2, wb_en, wb_rd, wb_data),
              ta, tb2, top, trd, twe, till);
        ea = ta; eb = tb2; eop = top; erd = trd; ewe = twe; eill = till;
        ev = 1'b1;
      end else if (out_ready) begin
        ev = 1'b0;
      end
      if (wb_en && wb_rd != 0) mreg[wb_rd] = wb_data;
      tick();
      chk("rnd_valid", out_valid, ev);
      if (ev) begin
        chk("rnd_illegal", illegal, eill);
        chk("rnd_rd_we", rd_we, ewe);
        chk("rnd_op", alu_op, eop);
        if (!eill) begin
          chk("rnd_a", alu_a, ea);
          chk("rnd_b", alu_b, eb);
          chk("rnd_rd", rd, erd);
        end
      end
    end
    in_valid = 1'b0; wb_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
